// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter: one double-dabble step per cycle under a small
// IDLE/CALC/DONE controller, with val/rdy handshakes on both the operand and the result.
module bin2bcd_seq_ctrl #(
   parameter int nbits   = 8,
   parameter int ndigits = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_val,
   output logic                   in_rdy,
   input  logic [nbits-1:0]       in_,
   output logic                   out_val,
   input  logic                   out_rdy,
   output logic [4*ndigits-1:0]   out
);

   // Handshake semantics: a transfer happens on a rising edge where val and rdy are both
   // high; rdy never depends combinationally on val, and a producer holds its data
   // stable while val is high and rdy is low.

   function automatic longint pow10(input int n);
      longint p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   localparam longint P10    = pow10(ndigits);
   localparam longint MAXBIN = (longint'(1) << nbits) - 1;

   if (nbits < 4 || nbits > 16 || P10 <= MAXBIN) begin : g_bad_params
      $error("bin2bcd_seq_ctrl: illegal nbits/ndigits combination");
   end

   localparam int CW = $clog2(nbits + 1);
   localparam int BW = 4 * ndigits;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [nbits-1:0] r_bin, w_bin_nxt, w_bin_step;
   logic [BW-1:0]    r_bcd, w_bcd_nxt, w_bcd_adj, w_bcd_step;
   logic [BW-1:0]    r_out, w_out_nxt;

   // Add-3 on every digit that would reach 10 or more after the doubling shift.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int k = 0; k < ndigits; k++) begin
         if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
   end

   assign w_bcd_step = {w_bcd_adj[BW-2:0], r_bin[nbits-1]};
   assign w_bin_step = {r_bin[nbits-2:0], 1'b0};

   assign in_rdy  = (r_state == IDLE) && !reset;
   assign out_val = (r_state == DONE) && !reset;
   assign out     = r_out;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bin_nxt   = r_bin;
      w_bcd_nxt   = r_bcd;
      w_out_nxt   = r_out;
      case (r_state)
         IDLE: begin
            if (in_val && in_rdy) begin
               w_bin_nxt   = in_;
               w_bcd_nxt   = '0;
               w_cnt_nxt   = CW'(nbits);
               w_state_nxt = CALC;
            end
         end
         CALC: begin
            w_bin_nxt = w_bin_step;
            w_bcd_nxt = w_bcd_step;
            w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
               w_out_nxt   = w_bcd_step;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_rdy) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_bin   <= '0;
         r_bcd   <= '0;
         r_out   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bin   <= w_bin_nxt;
         r_bcd   <= w_bcd_nxt;
         r_out   <= w_out_nxt;
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// Bench for bin2bcd_seq_ctrl: cycle-by-cycle comparison against a transaction-level model,
// directed scenarios with literal results, an exhaustive sweep and random traffic.
module tb_bin2bcd_seq_ctrl;

   localparam int NB = 8;
   localparam int ND = 3;

   logic          clk;
   logic          reset;
   logic          in_val;
   logic          in_rdy;
   logic [NB-1:0] in_;
   logic          out_val;
   logic          out_rdy;
   logic [11:0]   out;

   logic          d4_in_val;
   logic          d4_in_rdy;
   logic [3:0]    d4_in;
   logic          d4_out_val;
   logic          d4_out_rdy;
   logic [7:0]    d4_out;

   int n_checks = 0;
   int n_errors = 0;

   bin2bcd_seq_ctrl #(.nbits(NB), .ndigits(ND)) dut (
      .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_(in_),
      .out_val(out_val), .out_rdy(out_rdy), .out(out)
   );

   bin2bcd_seq_ctrl #(.nbits(4), .ndigits(2)) dut4 (
      .clk(clk), .reset(reset), .in_val(d4_in_val), .in_rdy(d4_in_rdy), .in_(d4_in),
      .out_val(d4_out_val), .out_rdy(d4_out_rdy), .out(d4_out)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] bcd12(input int v);
      return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   // ---------------- transaction-level model ----------------
   // m_age counts rising edges since the operand was accepted; the result becomes
   // visible after nbits edges and leaves on the first edge it is accepted downstream.
   logic        m_started = 1'b0;
   logic        m_pend;
   int          m_age;
   logic [7:0]  m_val;
   logic [11:0] m_out;

   always @(posedge clk) begin
      if (reset) begin
         m_started <= 1'b1;
         m_pend    <= 1'b0;
         m_age     <= 0;
         m_out     <= '0;
      end else if (m_started) begin
         if (!m_pend) begin
            if (in_val) begin
               m_pend <= 1'b1;
               m_val  <= in_;
               m_age  <= 0;
            end
         end else begin
            m_age <= m_age + 1;
            if (m_age + 1 == NB) m_out <= bcd12(int'(m_val));
            if (m_age >= NB && out_rdy) m_pend <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         chk("cyc_in_rdy", in_rdy, !m_pend && !reset);
         chk("cyc_out_val", out_val, m_pend && (m_age >= NB) && !reset);
         chk("cyc_out", out, m_out);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_op(input logic [7:0] v, input logic [11:0] exp_lit, input int hold,
                        input bit noise);
      int lat;
      int guard;
      guard = 0;
      while (!in_rdy && guard < 100) begin
         tick();
         guard++;
      end
      chk("op_start_rdy", in_rdy, 1);
      in_     = v;
      in_val  = 1'b1;
      out_rdy = (hold == 0);
      tick();
      lat = 0;
      while (!out_val && lat < 50) begin
         if (noise) in_ = 8'($urandom);
         else in_val = 1'b0;
         tick();
         lat++;
      end
      in_val = 1'b0;
      chk("op_latency", lat, NB);
      chk("op_result", out, exp_lit);
      for (int i = 0; i < hold; i++) begin
         chk("hold_out_val", out_val, 1);
         chk("hold_out", out, exp_lit);
         chk("hold_in_rdy", in_rdy, 0);
         tick();
      end
      out_rdy = 1'b1;
      tick();
      chk("op_idle_rdy", in_rdy, 1);
      chk("op_idle_val", out_val, 0);
   endtask

   task automatic d4_op(input logic [3:0] v, input logic [7:0] exp_lit);
      int lat;
      chk("d4_start_rdy", d4_in_rdy, 1);
      d4_in     = v;
      d4_in_val = 1'b1;
      tick();
      d4_in_val = 1'b0;
      lat = 0;
      while (!d4_out_val && lat < 50) begin
         tick();
         lat++;
      end
      chk("d4_latency", lat, 4);
      chk("d4_result", d4_out, exp_lit);
      tick();
      chk("d4_idle_rdy", d4_in_rdy, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset      = 1'b1;
      in_val     = 1'b1;
      in_        = 8'd77;
      out_rdy    = 1'b1;
      d4_in_val  = 1'b0;
      d4_in      = '0;
      d4_out_rdy = 1'b1;
      tick();
      tick();
      chk("rst_in_rdy", in_rdy, 0);
      chk("rst_out_val", out_val, 0);
      chk("rst_out", out, 0);
      in_val = 1'b0;
      reset  = 1'b0;
      tick();

      do_op(8'd0,   12'h000, 0, 1'b0);
      do_op(8'd10,  12'h010, 0, 1'b0);
      do_op(8'd99,  12'h099, 0, 1'b0);
      do_op(8'd255, 12'h255, 0, 1'b0);
      do_op(8'd128, 12'h128, 0, 1'b0);
      do_op(8'd37,  12'h037, 6, 1'b0);
      do_op(8'd200, 12'h200, 0, 1'b1);

      // Abandon a conversion during its fourth CALC cycle.
      in_    = 8'd173;
      in_val = 1'b1;
      tick();
      in_val = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      chk("midrst_out_val", out_val, 0);
      chk("midrst_out", out, 0);
      chk("midrst_in_rdy", in_rdy, 0);
      reset = 1'b0;
      tick();
      chk("midrst_idle", in_rdy, 1);
      do_op(8'd173, 12'h173, 0, 1'b0);

      for (int v = 0; v < 256; v++) do_op(8'(v), bcd12(v), 0, 1'b0);

      d4_op(4'd15, 8'h15);
      d4_op(4'd9,  8'h09);

      for (int c = 0; c < 2000; c++) begin
         in_val  = 1'($urandom_range(0, 1));
         in_     = 8'($urandom);
         out_rdy = ($urandom_range(0, 3) != 0);
         reset   = ($urandom_range(0, 299) == 0);
         tick();
      end
      reset   = 1'b0;
      in_val  = 1'b0;
      out_rdy = 1'b1;
      repeat (NB + 3) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
